// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter for one shared single-port memory
// Grants one port at a time, runs a req/ack bus cycle with watchdog, returns a ready pulse.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            err,
  output logic            busy
);

  localparam int MW  = DW / 8;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [MW-1:0]   m_wmask_q, m_wmask_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            pick_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmask_d = m_wmask_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = 1'b0;
    wd_d      = wd_q;
    pick_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // On a tie the port that was not served last wins.
          pick_d = d_req && (!i_req || (last_q == OWN_I));
          if (pick_d) begin
            owner_d   = OWN_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wmask_d = d_wmask;
          end else begin
            owner_d   = OWN_I;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wmask_d = '0;
          end
          last_d  = owner_d;
          wd_d    = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (m_ack) begin
          if (owner_q == OWN_D) d_rdata_d = m_rdata;
          else                  i_rdata_d = m_rdata;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
          // Ack is checked first, so an ack on the expiry cycle still completes cleanly.
          if ((TIMEOUT != 0) && (wd_d == WDW'(TIMEOUT))) begin
            if (owner_q == OWN_D) d_rdata_d = '0;
            else                  i_rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  assign m_req   = (state_q == S_BUS);
  assign busy    = (state_q != S_IDLE);
  assign i_ready = (state_q == S_RESP) && (owner_q == OWN_I);
  assign d_ready = (state_q == S_RESP) && (owner_q == OWN_D);
  assign err     = err_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wmask = m_wmask_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
